// File: rtl/cnt_sched_pkg.sv
// Shared types and helpers for the clock-enable burst scheduler.
// Holds the FSM state encoding and the burst-length decode rule.
package cnt_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A zero length field stands for the full counter range, 2**width enables.
  function automatic int unsigned len_decode(input int unsigned len,
                                             input int unsigned width);
    return (len == 0) ? (32'd1 << width) : len;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after last+1
// (mod N) wins. Produces a one-hot grant and the winner's index.
module rr_arbiter #(
  parameter  int N     = 2,
  localparam int OWN_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [OWN_W-1:0] last,
  output logic [N-1:0]     gnt,
  output logic [OWN_W-1:0] gnt_idx
);

  int               idx;
  logic [OWN_W-1:0] pos;
  logic             found;

  always_comb begin
    // NOTE: every output and temporary gets a default before the loop so no
    // path leaves a value unassigned, which would otherwise infer a latch.
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    pos     = '0;
    for (int off = 1; off <= N; off++) begin
      idx = (int'(last) + off) % N;
      pos = OWN_W'(idx);
      if (!found && req[pos]) begin
        gnt[pos] = 1'b1;
        gnt_idx  = pos;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cnt_en_sched.sv
// Shares one clock-enabled counter among NUM_REQ requesters: grants one burst
// at a time round-robin, drives clk_en for exactly N unheld cycles, then pulses done.
module cnt_en_sched
  import cnt_sched_pkg::*;
#(
  parameter  int NUM_REQ   = 2,
  parameter  int LEN_WIDTH = 4,
  localparam int OWN_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*LEN_WIDTH-1:0] req_len,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         hold,
  output logic                         clk_en,
  output logic                         busy,
  output logic [OWN_W-1:0]             owner,
  output logic [NUM_REQ-1:0]           done
);

  localparam logic [LEN_WIDTH:0] REM_ONE = (LEN_WIDTH+1)'(1);

  state_t                 state;
  logic [OWN_W-1:0]       last_grant;
  logic [OWN_W-1:0]       gnt_idx;
  logic [NUM_REQ-1:0]     gnt;
  logic [LEN_WIDTH:0]     remaining;
  logic [LEN_WIDTH-1:0]   sel_len;
  logic                   idle;
  logic                   handshake;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req     (req_valid),
    .last    (last_grant),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Grants only exist in IDLE, so hold never reaches req_ready.
  assign idle      = (state == IDLE);
  assign req_ready = idle ? gnt : '0;
  assign handshake = idle && (|req_valid);
  assign sel_len   = req_len[int'(gnt_idx)*LEN_WIDTH +: LEN_WIDTH];
  assign clk_en    = (state == RUN) && !hold;
  assign busy      = !idle;

  always_comb begin
    done = '0;
    if (state == DONE) done[owner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: all state updates use non-blocking assignment so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state      <= IDLE;
      last_grant <= OWN_W'(NUM_REQ - 1);
      owner      <= '0;
      remaining  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            owner     <= gnt_idx;
            remaining <= (LEN_WIDTH+1)'(len_decode(32'(sel_len), LEN_WIDTH));
            state     <= RUN;
          end
        end
        RUN: begin
          if (clk_en) begin
            remaining <= remaining - REM_ONE;
            if (remaining == REM_ONE) state <= DONE;
          end
        end
        DONE: begin
          last_grant <= owner;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cnt_en_sched.md
# cnt_en_sched

Round-robin scheduler that shares one clock-enabled counter among `NUM_REQ` requesters. Each requester asks for a burst of N enable cycles. The block grants one request at a time and drives the counter's `clk_en` for exactly N non-held cycles. It then pulses a per-requester done. It sits directly upstream of the counter's `clk_en` input; the counter's flag outputs are observed by the owning requester.

## Interface
Parameters:
- `NUM_REQ`, 2, number of requesters (2..8)
- `LEN_WIDTH`, 4, width of each burst-length field; matches the counter width
- `OWN_W`, `$clog2(NUM_REQ)` (min 1), owner index width; derived, not overridden

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  `NUM_REQ`  request pending, one bit per requester
- `req_len`  in  `NUM_REQ*LEN_WIDTH`  burst length per requester, requester i at bits [i*LEN_WIDTH +: LEN_WIDTH]
- `req_ready`  out  `NUM_REQ`  one-hot grant; a request is accepted when valid & ready
- `hold`  in  1  pauses the active burst
- `clk_en`  out  1  enable to the shared counter
- `busy`  out  1  burst in progress (RUN or DONE)
- `owner`  out  `OWN_W`  index of the granted requester; meaningful while `busy`
- `done`  out  `NUM_REQ`  one-hot, one-cycle completion pulse

## Operation
FSM states: IDLE, RUN, DONE.

- **IDLE**
  - If any `req_valid` bit is set, the round-robin pick asserts `req_ready[g]` combinationally in the same cycle. The search starts at `last_grant+1` mod `NUM_REQ`.
  - On that edge: `owner<=g`, `remaining<=req_len[g]`, state -> RUN.
  - If no request is pending, `req_ready` is 0.
- **RUN**
  - `clk_en = !hold`, combinational.
  - Each cycle with `clk_en=1` decrements `remaining`.
  - When `remaining==1` and `clk_en=1`, state -> DONE.
- **DONE**
  - `done[owner]=1` for one cycle.
  - `last_grant<=owner`, state -> IDLE.

Length and wrap rules:
- `req_len=0` means 2^LEN_WIDTH enables (16 by default).
- `remaining` is LEN_WIDTH+1 bits wide to hold that value.

Other rules:
- `req_ready` is 0 in RUN and DONE. A requester may drop or change `req_valid` or `req_len` at any time before its handshake; there is no lock-in.
- `req_len` is sampled only on the handshake edge. Changes during RUN are ignored.
- `hold` is ignored outside RUN.
- `busy=1` in RUN and DONE.

Reset values: state IDLE, `last_grant=NUM_REQ-1` (so requester 0 wins first after reset), `owner=0`, `remaining=0`. Resulting outputs: `clk_en=0`, `busy=0`, `done=0`, `req_ready` driven purely by `req_valid`.

Reset mid-burst: the burst is aborted with no `done` pulse, and `clk_en` is 0 from the cycle after the reset edge. The counter owner is responsible for resetting the counter as well.

## Timing
- Handshake at edge t (valid & ready high in cycle t).
- First `clk_en` in cycle t+1.
- With no hold, last `clk_en` in cycle t+len, `done` in cycle t+len+1.
- Earliest next handshake: cycle t+len+2.
- Each held cycle adds exactly one cycle to the burst. `hold` asserted continuously stalls indefinitely.
- Exactly N `clk_en` cycles per accepted burst, never N±1.
- No combinational path from `hold` to `req_ready`. Path `req_valid` -> `req_ready` is combinational only in IDLE.

## Structure
- Package `cnt_sched_pkg`: state enum (IDLE/RUN/DONE) and a `len_decode` function mapping 0 to 2^LEN_WIDTH.
- Sub-module `rr_arbiter`:
  - Parameter `N`.
  - Inputs: `req[N]`, `last[OWN_W]`.
  - Outputs: one-hot `gnt[N]`, `gnt_idx[OWN_W]`.
  - Purely combinational and reusable elsewhere.
- Top level holds the FSM, `remaining`, `owner` and `last_grant`.

## Test plan
- Reset, then `req_valid=2'b01`, `len=3` -> handshake at t, `clk_en` high t+1..t+3, `done=2'b01` at t+4, `busy` low at t+5.
- `req_valid=2'b11` held, both `len=2` -> grants alternate 0,1,0,1. Each burst gives exactly 2 `clk_en` cycles, with a 4-cycle grant spacing.
- `len=0` -> exactly 16 `clk_en` cycles. A downstream 4-bit counter starting at 0 ends back at 0.
- `len=4`, `hold` high on cycles t+2 and t+3 -> `clk_en` pattern 1,0,0,1,1,1 and `done` at t+7.
- Assert `rst` at t+2 of a `len=5` burst -> `clk_en=0` from t+3, no `done`, `busy=0`. Next grant goes to requester 0.
- `req_len` changed from 3 to 9 during RUN -> burst still delivers 3 enables.
